// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 bus constants, timing defaults and state encoding
package lcd_pkg;

  localparam int CLK_HZ = 50_000_000;

  // Defaults in 50 MHz cycles.
  localparam int DEF_T_SETUP  = 3;
  localparam int DEF_T_EPULSE = 12;
  localparam int DEF_T_HOLD   = 2;
  localparam int DEF_T_GAP    = 12;

  localparam int TIMER_W = 8;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } lcd_state_e;

endpackage

// File: rtl/lcd_cycle_timer.sv
// rtl/lcd_cycle_timer.sv - loadable down-counter; zero marks the last cycle of a timed phase
module lcd_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - timed HD44780 read cycle with optional busy-flag polling
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_EPULSE  = DEF_T_EPULSE,
  parameter int T_HOLD    = DEF_T_HOLD,
  parameter int T_GAP     = DEF_T_GAP,
  parameter int MAX_POLLS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [7:0] lcd_db_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_db_oe,
  output logic [7:0] data_out,
  output logic       busy_flag,
  output logic       ready,
  output logic       done,
  output logic       timeout
);

  localparam int CNT_W = $clog2(MAX_POLLS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_POLLS);

  lcd_state_e         state, next_state;
  logic               zero, load;
  logic [TIMER_W-1:0] load_value;
  logic               rs_lat, poll_lat, rs_next, active_next, timeout_next;
  logic [CNT_W-1:0]   poll_cnt;

  lcd_cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .zero       (zero)
  );

  always_comb begin
    next_state   = state;
    timeout_next = 1'b0;
    case (state)
      ST_IDLE:   if (start) next_state = ST_SETUP;
      ST_SETUP:  if (zero) next_state = ST_E_HIGH;
      ST_E_HIGH: if (zero) next_state = ST_HOLD;
      ST_HOLD:   if (zero) next_state = ST_GAP;
      ST_GAP: begin
        if (zero) begin
          if (poll_lat && data_out[7]) begin
            if (poll_cnt < MAX_CNT) begin
              next_state = ST_SETUP;
            end else begin
              next_state   = ST_DONE;
              timeout_next = 1'b1;
            end
          end else begin
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // The timer is reloaded with (duration - 1) whenever a new state is entered.
  always_comb begin
    load = (next_state != state);
    case (next_state)
      ST_SETUP:  load_value = TIMER_W'(T_SETUP - 1);
      ST_E_HIGH: load_value = TIMER_W'(T_EPULSE - 1);
      ST_HOLD:   load_value = TIMER_W'(T_HOLD - 1);
      ST_GAP:    load_value = TIMER_W'(T_GAP - 1);
      default:   load_value = '0;
    endcase
  end

  always_comb begin
    rs_next     = (state == ST_IDLE && start) ? rs_sel : rs_lat;
    active_next = (next_state == ST_SETUP) || (next_state == ST_E_HIGH) ||
                  (next_state == ST_HOLD)  || (next_state == ST_GAP);
  end

  // Bus outputs are registered from next_state so RW/OE only move on E-low cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rs_lat    <= 1'b0;
      poll_lat  <= 1'b0;
      poll_cnt  <= '0;
      data_out  <= 8'h00;
      lcd_e     <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db_oe <= 1'b1;
      ready     <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && start) begin
        rs_lat   <= rs_sel;
        poll_lat <= poll & (rs_sel == RS_CMD);
        poll_cnt <= '0;
      end
      if (state == ST_E_HIGH && zero) begin
        data_out <= lcd_db_in;
        if (poll_cnt != MAX_CNT) poll_cnt <= poll_cnt + CNT_W'(1);
      end
      lcd_e     <= (next_state == ST_E_HIGH);
      lcd_rw    <= active_next;
      lcd_db_oe <= ~active_next;
      lcd_rs    <= active_next & rs_next;
      ready     <= (next_state == ST_IDLE);
      done      <= (next_state == ST_DONE);
      timeout   <= timeout_next;
    end
  end

  assign busy_flag = data_out[7];

endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - self-checking bench for lcd_reader
module tb_lcd_reader;

  localparam int MAXP = 4;
  localparam int PULSE_LEN = 29;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll = 1'b0;
  logic [7:0] lcd_db_in = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_db_oe, busy_flag, ready, done, timeout;
  logic [7:0] data_out;

  int tests = 0;
  int fails = 0;

  lcd_reader #(.MAX_POLLS(MAXP)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rs_sel    (rs_sel),
    .poll      (poll),
    .lcd_db_in (lcd_db_in),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_db_oe (lcd_db_oe),
    .data_out  (data_out),
    .busy_flag (busy_flag),
    .ready     (ready),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Transaction model: phase p counts cycles from the accepted start edge;
  // each E pulse occupies 29 cycles, E high on offsets 3..14, done at 29*n+1.
  int         e_cnt = 0;
  int         k_m = 0;
  int         npulse = 0;
  int         end_p = 0;
  bit         active = 1'b0;
  bit         rs_m = 1'b0;
  bit         poll_m = 1'b0;
  bit         timeout_m = 1'b0;
  logic [7:0] data_m = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    = 1'b0;
      data_m    = 8'h00;
      timeout_m = 1'b0;
    end else begin
      int p_next;
      e_cnt++;
      if (!active) begin
        if (start) begin
          active    = 1'b1;
          k_m       = e_cnt;
          rs_m      = rs_sel;
          poll_m    = poll && !rs_sel;
          npulse    = 0;
          end_p     = 0;
          timeout_m = 1'b0;
        end
      end else begin
        p_next = e_cnt - k_m + 1;
        if (end_p == 0 && (p_next - 1) % PULSE_LEN == 15) begin
          data_m = lcd_db_in;
          npulse++;
          if (!(poll_m && data_m[7] && npulse < MAXP)) begin
            end_p     = PULSE_LEN * npulse + 1;
            timeout_m = poll_m && data_m[7];
          end
        end
        if (end_p != 0 && p_next == end_p + 1) active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] exp_v, act_v;
    int p, off;
    bit in_done;
    if (active) begin
      p       = e_cnt - k_m + 1;
      off     = (p - 1) % PULSE_LEN;
      in_done = (end_p != 0 && p == end_p);
      exp_v = {1'b0, in_done, in_done && timeout_m, !in_done && off >= 3 && off <= 14,
               !in_done, !in_done && rs_m, in_done, data_m[7], data_m};
    end else begin
      exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, data_m[7], data_m};
    end
    act_v = {ready, done, timeout, lcd_e, lcd_rw, lcd_rs, lcd_db_oe, busy_flag, data_out};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t {rdy,done,to,e,rw,rs,oe,bf,data} got=%b expected=%b",
               $time, act_v, exp_v);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_read(input logic rs, input logic pl, input logic [7:0] db0,
                          input int n_busy, input logic [7:0] db1, input bit inject,
                          output int pulses, output int e_cyc, output int done_p,
                          output int n_done, output int to_cnt, output int rs_cyc);
    int   p;
    logic prev_e;
    bit   fin;
    pulses = 0; e_cyc = 0; done_p = 0; n_done = 0; to_cnt = 0; rs_cyc = 0;
    prev_e = 1'b0; fin = 1'b0; p = 0;
    @(posedge clk); #2;
    lcd_db_in = db0; rs_sel = rs; poll = pl; start = 1'b1;
    while (!fin && p < 2000) begin
      @(posedge clk); #2;
      start = inject && (p + 1 == 20 || p + 1 == 30);
      @(negedge clk);
      p++;
      if (lcd_e) e_cyc++;
      if (lcd_e && !prev_e) pulses++;
      if (!lcd_e && prev_e && pulses == n_busy) lcd_db_in = db1;
      if (lcd_rs) rs_cyc++;
      if (done) begin n_done++; done_p = p; end
      if (timeout) to_cnt++;
      prev_e = lcd_e;
      if (done_p != 0 && p >= done_p + 3) fin = 1'b1;
    end
    start = 1'b0;
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL run_bound: got no done within %0d cycles expected done", p);
    end
  endtask

  initial begin
    int pulses, e_cyc, done_p, n_done, to_cnt, rs_cyc;

    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", ready, 1);
    check("rst_db_oe", lcd_db_oe, 1);
    check("rst_data", data_out, 8'h00);
    check("rst_e_rw", {lcd_e, lcd_rw, done, timeout}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_read(1'b0, 1'b0, 8'h25, 0, 8'h25, 1'b0, pulses, e_cyc, done_p, n_done, to_cnt, rs_cyc);
    check("busy_pulses", pulses, 1);
    check("busy_e_cycles", e_cyc, 12);
    check("busy_done_at", done_p, 30);
    check("busy_data", data_out, 8'h25);
    check("busy_bf", busy_flag, 0);

    run_read(1'b1, 1'b1, 8'hC1, 0, 8'hC1, 1'b0, pulses, e_cyc, done_p, n_done, to_cnt, rs_cyc);
    check("data_pulses", pulses, 1);
    check("data_rs_cycles", rs_cyc, 29);
    check("data_data", data_out, 8'hC1);
    check("data_timeout", to_cnt, 0);

    run_read(1'b0, 1'b1, 8'h80, 3, 8'h0A, 1'b0, pulses, e_cyc, done_p, n_done, to_cnt, rs_cyc);
    check("poll_pulses", pulses, 4);
    check("poll_done_at", done_p, 30 + 3 * 29);
    check("poll_data", data_out, 8'h0A);
    check("poll_timeout", to_cnt, 0);

    run_read(1'b0, 1'b1, 8'hFF, 0, 8'hFF, 1'b0, pulses, e_cyc, done_p, n_done, to_cnt, rs_cyc);
    check("to_pulses", pulses, 4);
    check("to_done_at", done_p, 117);
    check("to_timeout", to_cnt, 1);
    check("to_data", data_out, 8'hFF);
    check("to_bf", busy_flag, 1);

    // Reset in the 6th E-high cycle must drop the bus without a clock edge.
    @(posedge clk); #2;
    rs_sel = 1'b0; poll = 1'b0; lcd_db_in = 8'h77; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("pre_reset_e", lcd_e, 1);
    #1 reset = 1'b0;
    #1;
    check("async_e", lcd_e, 0);
    check("async_rw", lcd_rw, 0);
    check("async_done", done, 0);
    check("async_oe", lcd_db_oe, 1);
    check("async_ready", ready, 1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    run_read(1'b0, 1'b0, 8'h3C, 0, 8'h3C, 1'b0, pulses, e_cyc, done_p, n_done, to_cnt, rs_cyc);
    check("post_rst_done_at", done_p, 30);
    check("post_rst_data", data_out, 8'h3C);

    run_read(1'b0, 1'b0, 8'h5A, 0, 8'h5A, 1'b1, pulses, e_cyc, done_p, n_done, to_cnt, rs_cyc);
    check("inject_pulses", pulses, 1);
    check("inject_dones", n_done, 1);
    check("inject_done_at", done_p, 30);
    check("inject_ready", ready, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

endmodule
